ext_ram_frame_ctrl: RTL
=======================

# ext_ram_frame_ctrl

Master-side controller for the single-port `EXT_RAM` frame buffer: it drives the RAM's address, data, write-enable and chip-select pins.
- Fill phase: accepts one frame of `FRAME_LEN` words on a valid/ready input stream and writes them to RAM addresses 0..`FRAME_LEN`-1.
- Drain phase: reads the same frame back in address order onto a valid/ready output stream, marking the last word.

It sits between the channel-LLR input stage and the LDPC decoder core, turning the raw RAM pins into a streaming frame buffer.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width (matches `EXT_RAM`).
- `ADDR_WIDTH`, 8, RAM address width.
- `RAM_DEPTH`, 1 << `ADDR_WIDTH`, RAM word count.
- `FRAME_LEN`, `RAM_DEPTH`, words per frame; legal range 1..`RAM_DEPTH`.

Ports:
- One clock; reset is asynchronous and active-high. Clock is `clk`, reset is `rst`.
- `clk` in 1: rising-edge clock, shared with `EXT_RAM`.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous abort to IDLE.
- `s_data` in `DATA_WIDTH`: input word.
- `s_valid` in 1: input word present.
- `s_ready` out 1: controller accepts the input word this cycle.
- `m_data` out `DATA_WIDTH`: output word (registered).
- `m_valid` out 1: output word present.
- `m_last` out 1: current output word is the final word of the frame.
- `m_ready` in 1: downstream accepts the output word.
- `frame_done` out 1: one-cycle pulse after the last output word is accepted.
- `busy` out 1: high whenever the state is not IDLE.
- `ram_address` out `ADDR_WIDTH`: drives `EXT_RAM.address`.
- `ram_data_in` out `DATA_WIDTH`: drives `EXT_RAM.data_in`.
- `ram_write_en` out 1: drives `EXT_RAM.write_en`.
- `ram_chip_sel` out 1: drives `EXT_RAM.chip_sel`.
- `ram_data_out` in `DATA_WIDTH`: from `EXT_RAM.data_out`.

## Operation
RAM contract:
- Write on `clk` rising edge when `chip_sel & write_en`.
- Read is combinational: `data_out` equals mem[`address`] in the same cycle when `chip_sel & !write_en`.

States: IDLE, FILL, DRAIN. `wr_ptr` and `rd_ptr` are each `ADDR_WIDTH`+1 bits.

IDLE:
- `s_ready`=1.
- On `s_valid`: write `s_data` to address 0, set `wr_ptr`=1, go to FILL.
- If `FRAME_LEN`==1, go directly to DRAIN instead.

FILL:
- `s_ready`=1.
- Each `s_valid` cycle writes `s_data` at `wr_ptr` and increments `wr_ptr`.
- The write at `wr_ptr`==`FRAME_LEN`-1 moves the state to DRAIN and clears `rd_ptr` to 0.
- `s_valid` gaps stall FILL with no RAM access.

DRAIN:
- `s_ready`=0.
- fetch = `rd_ptr`<`FRAME_LEN` & (!`m_valid` | `m_ready`).
- On fetch:
  - `ram_address`=`rd_ptr`, `ram_chip_sel`=1, `ram_write_en`=0.
  - Next edge: `m_data` <= `ram_data_out`, `m_valid` <= 1, `m_last` <= (`rd_ptr`==`FRAME_LEN`-1), `rd_ptr`++.
- Otherwise, if `m_ready`: `m_valid` <= 0, `m_last` <= 0.
- When `m_valid & m_ready & m_last`: go to IDLE and assert `frame_done` for the next cycle.

RAM pin rules:
- `ram_data_in` = `s_data` (combinational, always).
- `ram_write_en` = `s_valid & s_ready`.
- `ram_chip_sel` = write | fetch.
- `ram_address` = `wr_ptr` on write, `rd_ptr` on fetch, otherwise 0.
- Write and read never occur in the same cycle.

flush (any state):
- Next state is IDLE; `wr_ptr`, `rd_ptr`, `m_valid` and `m_last` clear.
- No `frame_done`.
- No RAM write in the flush cycle (`s_ready`=0 while `flush`=1).
- RAM contents are not cleared.

## Timing
- Reset (asynchronous): state IDLE, pointers 0, `m_valid`/`m_last`/`m_data`/`frame_done`=0.
- Combinational outputs in reset/IDLE: `busy`=0, `s_ready`=1, `ram_write_en`=`s_valid`, `ram_address`=0.
- Reset mid-frame: partial frame discarded; the next accepted word is written to address 0.
- Fill throughput: 1 word/cycle, zero latency from the `s_valid&s_ready` edge to the RAM write.
- Drain throughput: 1 word/cycle while `m_ready`=1.
- First `m_valid` rises 2 edges after the final input write: 1 edge to enter DRAIN, then 1 fetch edge.
- `m_data`/`m_valid`/`m_last` hold stable while `m_valid & !m_ready`.
- Minimum frame turnaround (`m_ready`=1, no gaps): `FRAME_LEN` fill + 1 + `FRAME_LEN` drain cycles; `frame_done` follows 1 cycle after the last handshake.

## Test plan
- Reset, then `FRAME_LEN`=4, stream 75,13,24,200 with `s_valid` held high.
  - Required: RAM writes at addresses 0..3, one per cycle.
  - Required: `m_data` emits 75,13,24,200 with `m_last` only on 200, then a one-cycle `frame_done` pulse.
- Input gaps: `s_valid` pattern 1,0,1,1,0,1 for the 4 words.
  - Required: no RAM access in gap cycles; output order unchanged.
- Output backpressure: `m_ready` low for 3 cycles while `m_data`=13.
  - Required: `m_data`, `m_valid` and `m_last` stable; no extra fetch; 24 follows after `m_ready` rises.
- `FRAME_LEN`=1, single word 0xA5.
  - Required: immediate DRAIN; `m_data`=0xA5 with `m_last`=1; `frame_done` pulse.
- `flush` after 2 words (0x11, 0x22) of a 4-word frame, then send a new frame 1,2,3,4.
  - Required: output is 1,2,3,4; no `frame_done` for the aborted frame.
- Assert `rst` mid-DRAIN (after 2 outputs).
  - Required: `m_valid`=0 immediately (asynchronous), `busy`=0, `s_ready`=1.
  - Required: the next frame is written starting at address 0.

Source files
------------

// File: rtl/ext_ram_frame_ctrl_if.sv
// Bundle of stream, status and EXT_RAM pin signals for the frame buffer controller.
// The master modport is the controller's view; slave is the surrounding logic and RAM.
interface ext_ram_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  flush;

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  logic                  frame_done;
  logic                  busy;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_write_en;
  logic                  ram_chip_sel;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport master (
    input  flush, s_data, s_valid, m_ready, ram_data_out,
    output s_ready, m_data, m_valid, m_last, frame_done, busy,
           ram_address, ram_data_in, ram_write_en, ram_chip_sel
  );

  modport slave (
    output flush, s_data, s_valid, m_ready, ram_data_out,
    input  s_ready, m_data, m_valid, m_last, frame_done, busy,
           ram_address, ram_data_in, ram_write_en, ram_chip_sel
  );
endinterface

// File: rtl/ext_ram_frame_ctrl.sv
// Frame buffer controller for the single-port EXT_RAM. One frame is written
// into addresses 0..FRAME_LEN-1 from the input stream, then read back in
// address order onto the output stream with the final word flagged.
module ext_ram_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int FRAME_LEN  = RAM_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  ext_ram_frame_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  // A frame can never be longer than the RAM, so an oversized setting is
  // limited to the RAM depth rather than wrapping the address space.
  localparam int LEN_INT = (FRAME_LEN > RAM_DEPTH) ? RAM_DEPTH : FRAME_LEN;
  localparam logic [ADDR_WIDTH:0] ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] LEN  = (ADDR_WIDTH+1)'(LEN_INT);
  localparam logic [ADDR_WIDTH:0] LAST = LEN - ONE;

  state_t                state;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic                  frame_done_q;
  logic                  write;
  logic                  fetch;

  // RAM pin decode: a write while filling, a fetch while draining, never both.
  always_comb begin
    bus.s_ready      = (state != DRAIN) && !bus.flush;
    write            = bus.s_valid && bus.s_ready;
    fetch            = (state == DRAIN) && (rd_ptr < LEN) && (!m_valid_q || bus.m_ready);
    bus.ram_data_in  = bus.s_data;
    bus.ram_write_en = write;
    bus.ram_chip_sel = write || fetch;
    bus.ram_address  = '0;
    if (write) begin
      bus.ram_address = wr_ptr[ADDR_WIDTH-1:0];
    end else if (fetch) begin
      bus.ram_address = rd_ptr[ADDR_WIDTH-1:0];
    end
  end

  // Frame sequencing: pointers, output register and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.flush) begin
        state     <= IDLE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (write) begin
              wr_ptr <= ONE;
              rd_ptr <= '0;
              state  <= (LEN == ONE) ? DRAIN : FILL;
            end
          end
          FILL: begin
            if (write) begin
              wr_ptr <= wr_ptr + ONE;
              if (wr_ptr == LAST) begin
                state  <= DRAIN;
                rd_ptr <= '0;
              end
            end
          end
          DRAIN: begin
            if (fetch) begin
              m_data_q  <= bus.ram_data_out;
              m_valid_q <= 1'b1;
              m_last_q  <= (rd_ptr == LAST);
              rd_ptr    <= rd_ptr + ONE;
            end else if (bus.m_ready) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
            end
            if (m_valid_q && bus.m_ready && m_last_q) begin
              state        <= IDLE;
              wr_ptr       <= '0;
              frame_done_q <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state != IDLE);

endmodule
